expect_change_chk: RTL and testbench
====================================

# expect_change_chk

Multi-channel hardware change checker: the synthesizable counterpart of a bench `expect(@(posedge clk) ##[min:max] $changed(x))` with an optional value consequent. Each channel is armed with a window, watches its input for a change, and reports pass, fail or timeout plus the latency in cycles. The block sits beside the datapath as an on-chip monitor; results feed status registers or a bench scoreboard.

## Interface
- `N_CH`, 4: number of independent channels
- `W`, 8: data width per channel
- `CNT_W`, 16: window/latency counter width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `din`  in  N_CH*W  monitored values; channel i is `din[i*W +: W]`
- `arm`  in  N_CH  1-cycle start pulse per channel
- `abort`  in  N_CH  cancel a running check; no result is reported
- `mode`  in  N_CH  sampled at arm: 0 = ANY change passes, 1 = VALUE, where the change must land on `exp_val`
- `exp_val`  in  N_CH*W  expected post-change value, sampled at arm
- `min_dly`, `max_dly`  in  N_CH*CNT_W  window bounds, sampled at arm; `max_dly==0` means unbounded
- `busy`  out  N_CH  check in progress
- `done`  out  N_CH  1-cycle result strobe
- `pass`, `fail`  out  N_CH  result, held until the next arm
- `cfg_err`  out  N_CH  held with `fail`; set when `max_dly!=0` and `min_dly>max_dly`, or when `min_dly==0`
- `lat`  out  N_CH*CNT_W  edge index k at which the decision was made, held
- `overrun`  out  N_CH  sticky; set when arm arrives while busy; cleared only by reset

## Operation
- Per-channel FSM: IDLE → WAIT → (PASS | FAIL) → IDLE.
- **Arm edge (k=0):** latch mode, exp_val, min, max; `prev <= din`; `k <= 0`; clear pass, fail, cfg_err and lat.
  - Bad config: go directly to FAIL with `cfg_err`.
  - Otherwise go to WAIT.
- **WAIT:** at each edge, `k <= k+1` (saturating at all-ones) and `prev <= din`. A change at edge k means `din != prev`.
- Change with k < min → FAIL (early).
- Change with min ≤ k ≤ max, or max==0:
  - ANY mode → PASS.
  - VALUE mode → PASS iff `din == exp_val`, else FAIL.
- No change and k == max (max != 0) → FAIL (timeout).
- With max==0 the counter saturates at all-ones and the channel waits until abort or re-arm.
- PASS/FAIL last one cycle: `done=1`, `lat=k`, then return to IDLE.
- **abort** in WAIT → IDLE; no done, flags stay cleared. Abort in IDLE is ignored. Arm has priority over abort in the same cycle.
- **arm while busy:** restarts the check (k=0, new config, new baseline) and sets `overrun`.
- Arm in the PASS/FAIL cycle: the done for the old check still fires, and the new check starts.
- Channels are fully independent; no arbitration.

## Timing
- Reset (async assert, sync deassert is the integrator's responsibility): state IDLE; all outputs 0.
- A decision evaluated at edge k is visible (done, pass/fail, lat) in the cycle following edge k.
- `busy` rises the cycle after the arm edge and falls together with the done cycle.
- Minimum arm-to-done latency: 1 cycle for a cfg error, 2 cycles for a change at k=1.
- Reset asserted mid-WAIT aborts silently: no done pulse, all outputs 0.

## Structure
- Package `expect_chk_pkg`:
  - `state_t` enum {IDLE, WAIT, PASS, FAIL}
  - `mode_t` enum {MODE_ANY, MODE_VALUE}
  - default width constants
- Sub-module `expect_chk_chan` holds one channel's FSM, counter and baseline register.
- The top generates N_CH instances and slices the packed buses.

## Test plan
- **ANY pass, unbounded:** ch0 ANY, min=1, max=0; arm at cycle 0, din 0→1 at edge 10 → done at cycle 11, pass=1, lat=10.
- **VALUE mode:** exp_val=1, din 0→1 at k=3 → pass. Repeat with exp_val=0 → fail, lat=3, cfg_err=0.
- **Timeout:** min=1, max=5, din constant → fail at k=5, lat=5. Repeat with a change at k=5 → pass.
- **Early change and bad config:**
  - min=3, change at k=1 → fail, lat=1.
  - min=4, max=2 → done at cycle 1, fail=1, cfg_err=1.
- **Control events:**
  - Re-arm at k=4 → overrun=1, k restarts, the later change at new k=2 gives lat=2.
  - Abort at k=3 → busy drops, no done.
  - Arm and abort in the same cycle → check starts.
- **Reset and independence:**
  - rst_n low at k=7 → all outputs 0 immediately, no done after release.
  - Four channels armed at staggered cycles with different windows → per-channel results match the model with no crosstalk.

Source files
------------

// File: rtl/expect_chk_pkg.sv
// Shared types and default widths for the multi-channel change checker.
package expect_chk_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, PASS, FAIL} state_t;
  typedef enum logic {MODE_ANY, MODE_VALUE} mode_t;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_W     = 8;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/expect_chk_chan.sv
// One channel: armed with a window, watches din for a change against the
// previous sample and reports pass/fail with the edge index of the decision.
module expect_chk_chan
  import expect_chk_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     din,
  input  logic             arm,
  input  logic             abort,
  input  logic             mode,
  input  logic [W-1:0]     exp_val,
  input  logic [CNT_W-1:0] min_dly,
  input  logic [CNT_W-1:0] max_dly,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             cfg_err,
  output logic [CNT_W-1:0] lat,
  output logic             overrun
);

  state_t           r_state;
  state_t           w_state_nxt;
  mode_t            r_mode;
  logic [W-1:0]     r_exp;
  logic [W-1:0]     r_prev;
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;
  logic [CNT_W-1:0] r_k;
  logic [CNT_W-1:0] w_k_now;
  logic             w_cfg_bad;
  logic             w_change;
  logic             w_set_pass;
  logic             w_set_fail;

  always_comb begin
    w_state_nxt = r_state;
    w_set_pass  = 1'b0;
    w_set_fail  = 1'b0;
    w_cfg_bad   = (min_dly == '0) || ((max_dly != '0) && (min_dly > max_dly));
    // Edge index of the current edge; sticks at all-ones in unbounded waits.
    w_k_now     = (&r_k) ? r_k : r_k + CNT_W'(1);
    w_change    = (din != r_prev);
    if (arm) begin
      w_state_nxt = w_cfg_bad ? FAIL : WAIT;
    end else begin
      case (r_state)
        WAIT: begin
          if (abort) begin
            w_state_nxt = IDLE;
          end else if (w_change) begin
            if (w_k_now < r_min) begin
              w_set_fail = 1'b1;
            end else if ((r_mode == MODE_ANY) || (din == r_exp)) begin
              w_set_pass = 1'b1;
            end else begin
              w_set_fail = 1'b1;
            end
          end else if ((r_max != '0) && (w_k_now == r_max)) begin
            w_set_fail = 1'b1;
          end
          if (w_set_pass) w_state_nxt = PASS;
          if (w_set_fail) w_state_nxt = FAIL;
        end
        PASS, FAIL: w_state_nxt = IDLE;
        default:    w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      pass    <= 1'b0;
      fail    <= 1'b0;
      cfg_err <= 1'b0;
      lat     <= '0;
      overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (arm) begin
        pass    <= 1'b0;
        fail    <= w_cfg_bad;
        cfg_err <= w_cfg_bad;
        lat     <= '0;
        if (r_state == WAIT) overrun <= 1'b1;
      end else if (w_set_pass) begin
        pass <= 1'b1;
        lat  <= w_k_now;
      end else if (w_set_fail) begin
        fail <= 1'b1;
        lat  <= w_k_now;
      end
    end
  end

  // Window config and baseline are only consumed after an arm, so no reset.
  always_ff @(posedge clk) begin
    if (arm) begin
      r_mode <= mode_t'(mode);
      r_exp  <= exp_val;
      r_min  <= min_dly;
      r_max  <= max_dly;
      r_prev <= din;
      r_k    <= '0;
    end else if (r_state == WAIT) begin
      r_k    <= w_k_now;
      r_prev <= din;
    end
  end

  assign busy = (r_state == WAIT);
  assign done = (r_state == PASS) || (r_state == FAIL);

endmodule

// File: rtl/expect_change_chk.sv
// Multi-channel change checker: N_CH independent channels on packed buses.
module expect_change_chk
  import expect_chk_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*W-1:0]     din,
  input  logic [N_CH-1:0]       arm,
  input  logic [N_CH-1:0]       abort,
  input  logic [N_CH-1:0]       mode,
  input  logic [N_CH*W-1:0]     exp_val,
  input  logic [N_CH*CNT_W-1:0] min_dly,
  input  logic [N_CH*CNT_W-1:0] max_dly,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done,
  output logic [N_CH-1:0]       pass,
  output logic [N_CH-1:0]       fail,
  output logic [N_CH-1:0]       cfg_err,
  output logic [N_CH*CNT_W-1:0] lat,
  output logic [N_CH-1:0]       overrun
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    expect_chk_chan #(
      .W     (W),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (din[i*W +: W]),
      .arm     (arm[i]),
      .abort   (abort[i]),
      .mode    (mode[i]),
      .exp_val (exp_val[i*W +: W]),
      .min_dly (min_dly[i*CNT_W +: CNT_W]),
      .max_dly (max_dly[i*CNT_W +: CNT_W]),
      .busy    (busy[i]),
      .done    (done[i]),
      .pass    (pass[i]),
      .fail    (fail[i]),
      .cfg_err (cfg_err[i]),
      .lat     (lat[i*CNT_W +: CNT_W]),
      .overrun (overrun[i])
    );
  end

endmodule

// File: tb/tb_expect_change_chk.sv
// Directed bench for expect_change_chk: hand-computed results per scenario.
module tb_expect_change_chk;
  localparam int N_CH  = 4;
  localparam int W     = 8;
  localparam int CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [N_CH*W-1:0]     din = '0;
  logic [N_CH-1:0]       arm = '0;
  logic [N_CH-1:0]       abort = '0;
  logic [N_CH-1:0]       mode = '0;
  logic [N_CH*W-1:0]     exp_val = '0;
  logic [N_CH*CNT_W-1:0] min_dly = '0;
  logic [N_CH*CNT_W-1:0] max_dly = '0;
  logic [N_CH-1:0]       busy, done, pass, fail, cfg_err, overrun;
  logic [N_CH*CNT_W-1:0] lat;

  int checks = 0;
  int errors = 0;

  expect_change_chk #(.N_CH(N_CH), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .arm(arm), .abort(abort), .mode(mode),
    .exp_val(exp_val), .min_dly(min_dly), .max_dly(max_dly), .busy(busy),
    .done(done), .pass(pass), .fail(fail), .cfg_err(cfg_err), .lat(lat),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_din(input int ch, input int v);
    din[ch*W +: W] = W'(v);
  endtask

  task automatic arm_ch(input int ch, input bit md, input int ev, input int mn, input int mx);
    arm[ch] = 1'b1;
    mode[ch] = md;
    exp_val[ch*W +: W] = W'(ev);
    min_dly[ch*CNT_W +: CNT_W] = CNT_W'(mn);
    max_dly[ch*CNT_W +: CNT_W] = CNT_W'(mx);
  endtask

  function automatic logic [CNT_W-1:0] lat_of(input int ch);
    return lat[ch*CNT_W +: CNT_W];
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    tick(2);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_passfail", 64'({pass, fail}), 0);
    chk("rst_cfg_ovr", 64'({cfg_err, overrun}), 0);
    chk("rst_lat", 64'(lat), 0);
    rst_n = 1'b1;
    tick(1);

    // ANY, unbounded: change at edge 10
    arm_ch(0, 1'b0, 0, 1, 0);
    tick(1); arm = '0;
    chk("any_busy", 64'(busy[0]), 1);
    tick(9);
    chk("any_wait_done", 64'(done[0]), 0);
    set_din(0, 1);
    tick(1);
    chk("any_done", 64'(done[0]), 1);
    chk("any_pass", 64'({pass[0], fail[0]}), 2'b10);
    chk("any_lat", 64'(lat_of(0)), 10);
    chk("any_busy_fall", 64'(busy[0]), 0);
    tick(1);
    chk("any_done_1cyc", 64'(done[0]), 0);
    chk("any_pass_held", 64'(pass[0]), 1);

    // VALUE match, then mismatch
    set_din(0, 0);
    arm_ch(0, 1'b1, 1, 1, 0);
    tick(1); arm = '0;
    chk("val_clear", 64'(pass[0]), 0);
    tick(2);
    set_din(0, 1);
    tick(1);
    chk("val_pass", 64'({done[0], pass[0], fail[0]}), 3'b110);
    chk("val_lat", 64'(lat_of(0)), 3);
    set_din(0, 0);
    arm_ch(0, 1'b1, 0, 1, 0);
    tick(1); arm = '0;
    tick(2);
    set_din(0, 1);
    tick(1);
    chk("valx_fail", 64'({done[0], pass[0], fail[0]}), 3'b101);
    chk("valx_lat", 64'(lat_of(0)), 3);
    chk("valx_cfg", 64'(cfg_err[0]), 0);

    // Timeout at max, then change exactly at max
    set_din(0, 0);
    arm_ch(0, 1'b0, 0, 1, 5);
    tick(1); arm = '0;
    tick(4);
    chk("to_busy", 64'({busy[0], done[0]}), 2'b10);
    tick(1);
    chk("to_fail", 64'({done[0], pass[0], fail[0]}), 3'b101);
    chk("to_lat", 64'(lat_of(0)), 5);
    arm_ch(0, 1'b0, 0, 1, 5);
    tick(1); arm = '0;
    tick(4);
    set_din(0, 1);
    tick(1);
    chk("edge_max_pass", 64'({done[0], pass[0], fail[0]}), 3'b110);
    chk("edge_max_lat", 64'(lat_of(0)), 5);

    // Early change, bad configs
    set_din(0, 0);
    arm_ch(0, 1'b0, 0, 3, 0);
    tick(1); arm = '0;
    set_din(0, 1);
    tick(1);
    chk("early_fail", 64'({done[0], pass[0], fail[0]}), 3'b101);
    chk("early_lat", 64'(lat_of(0)), 1);
    arm_ch(0, 1'b0, 0, 4, 2);
    tick(1); arm = '0;
    chk("cfg_done", 64'({done[0], fail[0], cfg_err[0], busy[0]}), 4'b1110);
    chk("cfg_lat", 64'(lat_of(0)), 0);
    arm_ch(0, 1'b0, 0, 0, 0);
    tick(1); arm = '0;
    chk("cfg_min0", 64'({done[0], fail[0], cfg_err[0]}), 3'b111);
    tick(1);
    chk("cfg_held", 64'({done[0], fail[0], cfg_err[0]}), 3'b011);

    // Re-arm while busy
    set_din(0, 0);
    arm_ch(0, 1'b0, 0, 1, 0);
    tick(1); arm = '0;
    chk("ovr_pre", 64'(overrun[0]), 0);
    tick(3);
    arm_ch(0, 1'b0, 0, 1, 0);
    tick(1); arm = '0;
    chk("ovr_set", 64'({overrun[0], busy[0]}), 2'b11);
    tick(1);
    set_din(0, 1);
    tick(1);
    chk("ovr_lat", 64'({done[0], pass[0], lat_of(0)}), {2'b11, 16'd2});

    // Abort mid-wait
    arm_ch(0, 1'b0, 0, 1, 0);
    tick(1); arm = '0;
    tick(2);
    abort[0] = 1'b1;
    tick(1); abort = '0;
    chk("abort_idle", 64'({busy[0], done[0], pass[0], fail[0]}), 0);
    set_din(0, 0);
    tick(3);
    chk("abort_no_done", 64'({busy[0], done[0]}), 0);

    // Arm and abort together: arm wins
    arm_ch(0, 1'b0, 0, 1, 0);
    abort[0] = 1'b1;
    tick(1); arm = '0; abort = '0;
    chk("armabort_busy", 64'(busy[0]), 1);
    set_din(0, 1);
    tick(1);
    chk("armabort_pass", 64'({done[0], pass[0]}), 2'b11);

    // Reset mid-wait
    set_din(0, 0);
    arm_ch(0, 1'b0, 0, 1, 0);
    tick(1); arm = '0;
    tick(6);
    rst_n = 1'b0;
    #1;
    chk("rstw_outs", 64'({busy, done, pass, fail, cfg_err, overrun}), 0);
    chk("rstw_lat", 64'(lat), 0);
    tick(2);
    rst_n = 1'b1;
    set_din(0, 1);
    tick(3);
    chk("rstw_no_done", 64'({busy[0], done[0], pass[0], fail[0]}), 0);

    // Four channels, staggered
    din = '0;
    arm_ch(0, 1'b0, 0, 1, 0);
    tick(1); arm = '0;
    arm_ch(1, 1'b1, 8'h55, 2, 6);
    tick(1); arm = '0;
    arm_ch(2, 1'b0, 0, 1, 3);
    tick(1); arm = '0;
    arm_ch(3, 1'b0, 0, 5, 0);
    set_din(1, 8'h55);
    tick(1); arm = '0;
    chk("mc_e3_done", 64'(done), 4'b0010);
    chk("mc_e3_busy", 64'(busy), 4'b1101);
    chk("mc_ch1_lat", 64'(lat_of(1)), 2);
    set_din(0, 1);
    tick(1);
    chk("mc_e4_done", 64'(done), 4'b0001);
    chk("mc_e4_pass", 64'(pass), 4'b0011);
    chk("mc_ch0_lat", 64'(lat_of(0)), 4);
    set_din(3, 7);
    tick(1);
    chk("mc_e5_done", 64'(done), 4'b1100);
    chk("mc_e5_fail", 64'({fail, pass}), {4'b1100, 4'b0011});
    chk("mc_ch2_lat", 64'(lat_of(2)), 3);
    chk("mc_ch3_lat", 64'(lat_of(3)), 2);
    chk("mc_ovr_cfg", 64'({overrun, cfg_err, busy}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
